data_mem_handler: RTL and testbench
===================================

// Module: data_mem_handler
// PURPOSE
//   Responder for the memory-control outputs of the decode/control stage (read_mem, write_mem,
//   load_byte, store_byte). Turns one load/store into a single word-wide bus transaction and
//   stalls the core until the transaction ends. Builds byte lanes for sb and sign-extends lb data.
//   Sits between the execute stage (address = ALU result) and the external data-memory bus.
// PARAMETERS
//   TIMEOUT  16  max cycles in REQ waiting for bus_ack before the access is aborted (>=2)
// PORTS
//   clk           in   1   system clock, all state on rising edge
//   n_rst         in   1   asynchronous active-low reset
//   read_mem      in   1   load request from control logic; held by core while stall=1
//   write_mem     in   1   store request from control logic; held by core while stall=1
//   load_byte     in   1   load is lb (sign-extended byte); else lw
//   store_byte    in   1   store is sb; else sw
//   address       in   32  byte address from ALU
//   store_data    in   32  rs2 value for stores
//   load_data     out  32  load result; valid only in the cycle stall falls
//   stall         out  1   freeze pipeline; access in progress
//   misaligned    out  1   one-cycle pulse: lw/sw with address[1:0]!=0
//   bus_error     out  1   one-cycle pulse: bus_ack timeout
//   bus_addr      out  32  word address {address[31:2],2'b00}, registered
//   bus_wdata     out  32  write data, registered
//   bus_sel       out  4   byte enables, registered
//   bus_read      out  1   read strobe, registered
//   bus_write     out  1   write strobe, registered
//   bus_rdata     in   32  read data, sampled when bus_ack=1
//   bus_ack       in   1   transaction complete
// BEHAVIOUR
//   Reset: state=IDLE; all registered outputs, load_data, misaligned and bus_error = 0.
//     Async: strobes drop the instant n_rst falls, even mid-transaction. The core re-issues.
//   States: IDLE, REQ, DONE.
//   stall = (state==REQ) | (state==IDLE & (read_mem|write_mem)). Combinational.
//     stall=0 in DONE.
//   IDLE, with read_mem|write_mem:
//     - write_mem and read_mem both 1: store wins, read is ignored.
//     - Misaligned word access: no bus strobe. Go to DONE with misaligned=1 in DONE,
//       load_data=0.
//     - Otherwise latch bus_addr, bus_wdata, bus_sel and the strobe, clear the wait counter,
//       go to REQ.
//   Byte lanes:
//     - sw: sel=4'b1111, wdata=store_data.
//     - sb: sel=4'b0001<<address[1:0], wdata={4{store_data[7:0]}}.
//     - lw: sel=4'b1111.
//     - lb: sel=4'b0001<<address[1:0].
//   REQ: strobe held stable.
//     - bus_ack=1: capture bus_rdata and go to DONE.
//     - Otherwise the counter increments. When it reaches TIMEOUT-1 without ack: go to DONE
//       with bus_error=1 in DONE, load_data=0.
//   Leaving REQ: strobes clear on the same edge.
//   DONE: load_data is presented for exactly one cycle.
//     - lw: the captured word.
//     - lb: sign-extended byte at lane address[1:0].
//     - Stores: load_data=0.
//     Next state is IDLE. A request still asserted in the next cycle counts as a new access.
//   Latency:
//     - Request seen at cycle N, ack at N+k (k>=1): stall high N..N+k, DONE/result at N+k+1.
//       Minimum 3 cycles.
//     - Misaligned: stall high at N only, DONE at N+1.
//   bus_ack outside REQ is ignored.
//   The wait counter is ceil(log2(TIMEOUT)) bits wide and never wraps.
// TESTING
//   lw 0x0000_1000, ack 2 cycles after strobe, rdata 0xDEAD_BEEF
//     -> sel=1111, load_data=0xDEADBEEF in DONE, stall high 3 cycles.
//   lb 0x0000_1003, rdata 0x80AA_BBCC
//     -> sel=1000, load_data=0xFFFF_FF80; same at 0x1001 -> 0xFFFF_FFBB.
//   sb 0x0000_0101, store_data 0x1234_56AB
//     -> bus_addr=0x100, sel=0010, wdata=0xABAB_ABAB, bus_write=1 until ack.
//   sw 0x0000_0102
//     -> no bus_read/bus_write ever, misaligned pulses 1 cycle, stall high 1 cycle.
//   lw, ack never arrives (TIMEOUT=16)
//     -> strobe high 16 cycles, then bus_error 1 cycle, load_data=0, back to IDLE.
//   n_rst low during REQ
//     -> bus_read=0 immediately; after release state IDLE; held request restarts cleanly.

Source files
------------

// File: rtl/data_mem_handler.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_handler
// Purpose  : Turns one core load/store into a single word-wide bus transaction,
//            stalling the pipeline until it ends; builds sb lanes, sign-extends lb.
// Revision : 1.0
// ============================================================================
module data_mem_handler #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic [1:0]  lane_q, lane_d;
  logic        is_lb_q, is_lb_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;

  logic        req_w;
  logic        byte_w;
  logic        mis_w;
  logic [3:0]  sel_w;
  logic [31:0] wdata_w;
  logic [31:0] rshift_w;
  logic [7:0]  rbyte_w;
  logic        last_w;

  // A simultaneous store and load resolves to the store.
  assign req_w    = read_mem | write_mem;
  assign byte_w   = write_mem ? store_byte : load_byte;
  assign mis_w    = !byte_w && (address[1:0] != 2'b00);
  assign sel_w    = byte_w ? (4'b0001 << address[1:0]) : 4'b1111;
  assign wdata_w  = store_byte ? {4{store_data[7:0]}} : store_data;
  assign rshift_w = bus_rdata >> {lane_q, 3'b000};
  assign rbyte_w  = rshift_w[7:0];
  assign last_w   = (cnt_q == CW'(TIMEOUT - 1));

  assign stall = (state_q == REQ) || ((state_q == IDLE) && req_w);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_sel_d    = bus_sel_q;
    bus_read_d   = bus_read_q;
    bus_write_d  = bus_write_q;
    lane_d       = lane_q;
    is_lb_d      = is_lb_q;
    load_data_d  = 32'h0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_w) begin
          if (mis_w) begin
            state_d      = DONE;
            misaligned_d = 1'b1;
          end else begin
            state_d     = REQ;
            bus_addr_d  = {address[31:2], 2'b00};
            bus_wdata_d = wdata_w;
            bus_sel_d   = sel_w;
            bus_read_d  = !write_mem;
            bus_write_d = write_mem;
            cnt_d       = '0;
            lane_d      = address[1:0];
            is_lb_d     = !write_mem && load_byte;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d     = DONE;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          if (bus_read_q) begin
            load_data_d = is_lb_q ? {{24{rbyte_w[7]}}, rbyte_w} : bus_rdata;
          end
        end else if (last_w) begin
          state_d     = DONE;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      bus_sel_q    <= 4'h0;
      bus_read_q   <= 1'b0;
      bus_write_q  <= 1'b0;
      lane_q       <= 2'b00;
      is_lb_q      <= 1'b0;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_sel_q    <= bus_sel_d;
      bus_read_q   <= bus_read_d;
      bus_write_q  <= bus_write_d;
      lane_q       <= lane_d;
      is_lb_q      <= is_lb_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_sel    = bus_sel_q;
  assign bus_read   = bus_read_q;
  assign bus_write  = bus_write_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_handler.sv
`default_nettype none
// Bench for data_mem_handler: directed scenarios plus randomized accesses
// checked against a transaction-level model with a responsive bus.
module tb_data_mem_handler;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        read_mem = 1'b0, write_mem = 1'b0, load_byte = 1'b0, store_byte = 1'b0;
  logic [31:0] address = 32'h0, store_data = 32'h0;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic        stall, misaligned, bus_error, bus_read, bus_write;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  // Observations captured by the access driver.
  logic        obs_ok, obs_rd, obs_wr, obs_unstable, obs_mis, obs_err;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  logic [3:0]  obs_sel;
  int          obs_stall_n, obs_strobe_n;

  data_mem_handler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst),
    .read_mem(read_mem), .write_mem(write_mem),
    .load_byte(load_byte), .store_byte(store_byte),
    .address(address), .store_data(store_data),
    .load_data(load_data), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_read(bus_read), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  // Called just after a falling edge. Holds the request while stall is high,
  // acks on the ack_delay-th strobe cycle (0 = never), drops request in DONE.
  task automatic do_access(input logic rd, input logic wr, input logic lb, input logic sb,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int ack_delay, input logic [31:0] rdata);
    bit done = 0;
    read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb;
    address = a; store_data = sd;
    obs_ok = 0; obs_unstable = 0; obs_stall_n = 0; obs_strobe_n = 0;
    obs_rd = 0; obs_wr = 0; obs_addr = 0; obs_wdata = 0; obs_sel = 0;
    obs_ld = 0; obs_mis = 0; obs_err = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) begin
        obs_stall_n++;
        if (bus_read || bus_write) begin
          obs_strobe_n++;
          if (obs_strobe_n == 1) begin
            obs_rd = bus_read; obs_wr = bus_write; obs_addr = bus_addr;
            obs_wdata = bus_wdata; obs_sel = bus_sel;
          end else if (bus_read !== obs_rd || bus_write !== obs_wr ||
                       bus_addr !== obs_addr || bus_sel !== obs_sel ||
                       bus_wdata !== obs_wdata) begin
            obs_unstable = 1;
          end
          bus_ack   = (obs_strobe_n == ack_delay);
          bus_rdata = (obs_strobe_n == ack_delay) ? rdata : $urandom;
        end else begin
          bus_ack   = 1'($urandom_range(0, 1));
          bus_rdata = $urandom;
        end
        @(negedge clk);
      end else begin
        obs_ld = load_data; obs_mis = misaligned; obs_err = bus_error;
        if (bus_read || bus_write) obs_unstable = 1;
        read_mem = 0; write_mem = 0; bus_ack = 0;
        obs_ok = 1; done = 1;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 0;
    #12;
    tests++; if ({bus_read, bus_write, misaligned, bus_error, stall} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 00000", {bus_read, bus_write, misaligned, bus_error, stall}); end
    tests++; if ({load_data, bus_addr, bus_wdata, bus_sel} !== 100'h0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", load_data, bus_addr, bus_wdata, bus_sel); end
    @(negedge clk); n_rst = 1;
  endtask

  task automatic test_lw();
    @(negedge clk);
    do_access(1, 0, 0, 0, 32'h0000_1000, 32'h0, 2, 32'hDEAD_BEEF);
    tests++; if (obs_sel !== 4'b1111 || obs_addr !== 32'h1000 || obs_rd !== 1'b1) begin
      fails++; $display("FAIL lw_bus got sel=%b addr=%h rd=%b exp 1111/1000/1", obs_sel, obs_addr, obs_rd); end
    tests++; if (obs_ld !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL lw_data got %h exp deadbeef", obs_ld); end
    tests++; if (obs_stall_n != 3 || !obs_ok) begin
      fails++; $display("FAIL lw_stall got %0d ok=%b exp 3", obs_stall_n, obs_ok); end
  endtask

  task automatic test_lb();
    @(negedge clk);
    do_access(1, 0, 1, 0, 32'h0000_1003, 32'h0, 1, 32'h80AA_BBCC);
    tests++; if (obs_sel !== 4'b1000 || obs_ld !== 32'hFFFF_FF80) begin
      fails++; $display("FAIL lb3 got sel=%b data=%h exp 1000/ffffff80", obs_sel, obs_ld); end
    @(negedge clk);
    do_access(1, 0, 1, 0, 32'h0000_1001, 32'h0, 3, 32'h80AA_BBCC);
    tests++; if (obs_sel !== 4'b0010 || obs_ld !== 32'hFFFF_FFBB) begin
      fails++; $display("FAIL lb1 got sel=%b data=%h exp 0010/ffffffbb", obs_sel, obs_ld); end
  endtask

  task automatic test_sb();
    @(negedge clk);
    do_access(0, 1, 0, 1, 32'h0000_0101, 32'h1234_56AB, 4, 32'h5555_5555);
    tests++; if (obs_addr !== 32'h100 || obs_sel !== 4'b0010 || obs_wdata !== 32'hABAB_ABAB) begin
      fails++; $display("FAIL sb_bus got addr=%h sel=%b wd=%h exp 100/0010/abababab", obs_addr, obs_sel, obs_wdata); end
    tests++; if (obs_wr !== 1'b1 || obs_rd !== 1'b0 || obs_strobe_n != 4 || obs_unstable || obs_ld !== 32'h0) begin
      fails++; $display("FAIL sb_strobe got wr=%b rd=%b n=%0d unst=%b ld=%h exp 1/0/4/0/0", obs_wr, obs_rd, obs_strobe_n, obs_unstable, obs_ld); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    do_access(0, 1, 0, 0, 32'h0000_0102, 32'hCAFE_F00D, 1, 32'h0);
    tests++; if (obs_strobe_n != 0 || obs_stall_n != 1 || obs_mis !== 1'b1 || obs_ld !== 32'h0) begin
      fails++; $display("FAIL sw_mis got strobes=%0d stall=%0d mis=%b ld=%h exp 0/1/1/0", obs_strobe_n, obs_stall_n, obs_mis, obs_ld); end
    @(negedge clk); #1;
    tests++; if (misaligned !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL mis_pulse got mis=%b stall=%b exp 0/0", misaligned, stall); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    do_access(1, 0, 0, 0, 32'h0000_2000, 32'h0, 0, 32'h0);
    tests++; if (obs_strobe_n != TIMEOUT || obs_err !== 1'b1 || obs_ld !== 32'h0 || !obs_ok) begin
      fails++; $display("FAIL timeout got strobes=%0d err=%b ld=%h ok=%b exp 16/1/0/1", obs_strobe_n, obs_err, obs_ld, obs_ok); end
    @(negedge clk); #1;
    tests++; if (bus_error !== 1'b0 || stall !== 1'b0 || bus_read !== 1'b0) begin
      fails++; $display("FAIL timeout_idle got err=%b stall=%b rd=%b exp 0/0/0", bus_error, stall, bus_read); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    read_mem = 1; write_mem = 0; load_byte = 0; address = 32'h0000_3000; bus_ack = 0;
    @(negedge clk); #1;
    tests++; if (bus_read !== 1'b1) begin
      fails++; $display("FAIL arst_pre got rd=%b exp 1", bus_read); end
    #1 n_rst = 0;
    #1;
    tests++; if (bus_read !== 1'b0 || bus_sel !== 4'h0 || stall !== 1'b1) begin
      fails++; $display("FAIL arst_drop got rd=%b sel=%b stall=%b exp 0/0000/1", bus_read, bus_sel, stall); end
    @(negedge clk); n_rst = 1;
    do_access(1, 0, 0, 0, 32'h0000_3000, 32'h0, 2, 32'h0BAD_CAFE);
    tests++; if (obs_stall_n != 3 || obs_ld !== 32'h0BAD_CAFE || obs_strobe_n != 2) begin
      fails++; $display("FAIL arst_restart got stall=%0d ld=%h n=%0d exp 3/0badcafe/2", obs_stall_n, obs_ld, obs_strobe_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic rd, wr, lb, sb, is_store, is_byte, exp_mis, exp_err;
      logic [31:0] a, sd, rdata, exp_ld, exp_wd, b;
      logic [3:0] exp_sel;
      int d, off, exp_strobes;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1;
      lb = 1'($urandom); sb = 1'($urandom);
      a = $urandom; sd = $urandom; rdata = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      // Transaction-level expectations.
      is_store = wr;
      is_byte  = is_store ? sb : lb;
      off      = int'(a % 4);
      exp_mis  = !is_byte && off != 0;
      exp_err  = !exp_mis && d == 0;
      exp_strobes = exp_mis ? 0 : (d == 0 ? TIMEOUT : d);
      exp_sel  = is_byte ? 4'(1 << off) : 4'hF;
      exp_wd   = sb ? (sd & 32'hFF) * 32'h0101_0101 : sd;
      b        = (rdata >> (8 * off)) & 32'hFF;
      exp_ld   = 32'h0;
      if (!is_store && !exp_mis && !exp_err)
        exp_ld = !is_byte ? rdata : (b >= 128 ? b + 32'hFFFF_FF00 : b);
      @(negedge clk);
      do_access(rd, wr, lb, sb, a, sd, d, rdata);
      tests++; if (!obs_ok || obs_mis !== exp_mis || obs_err !== exp_err ||
                   obs_strobe_n != exp_strobes || obs_stall_n != 1 + exp_strobes || obs_unstable) begin
        fails++; $display("FAIL rnd%0d_ctrl got ok=%b mis=%b err=%b n=%0d stall=%0d unst=%b exp mis=%b err=%b n=%0d",
                          i, obs_ok, obs_mis, obs_err, obs_strobe_n, obs_stall_n, obs_unstable, exp_mis, exp_err, exp_strobes); end
      tests++; if (obs_ld !== exp_ld) begin
        fails++; $display("FAIL rnd%0d_data got %h exp %h", i, obs_ld, exp_ld); end
      if (!exp_mis) begin
        tests++; if (obs_addr !== (a & 32'hFFFF_FFFC) || obs_sel !== exp_sel ||
                     obs_rd !== !is_store || obs_wr !== is_store ||
                     (is_store && obs_wdata !== exp_wd)) begin
          fails++; $display("FAIL rnd%0d_bus got a=%h sel=%b rd=%b wr=%b wd=%h exp a=%h sel=%b wd=%h",
                            i, obs_addr, obs_sel, obs_rd, obs_wr, obs_wdata, a & 32'hFFFF_FFFC, exp_sel, exp_wd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sb();
    test_misaligned();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
